rs_station: RTL

//  Reservation station: receiving end of the rename/dispatch -> RS interface. Holds DEPTH

---
 rtl/rs_station.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rs_station.sv
// Reservation station for one functional unit: holds dispatched uops, wakes operands from
// the CDB buses, and issues the oldest ready uop over a valid/ready handshake.
module rs_station #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int NUM_CDB   = 4,
    parameter int PAYLOAD_W = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    input  logic                     disp_busy1,
    input  logic                     disp_busy2,
    input  logic [TAG_W-1:0]         disp_tag1,
    input  logic [TAG_W-1:0]         disp_tag2,
    input  logic [31:0]              disp_v1,
    input  logic [31:0]              disp_v2,
    input  logic [TAG_W-1:0]         disp_rob,
    input  logic [PAYLOAD_W-1:0]     disp_payload,
    output logic                     full,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*32-1:0]    cdb_value,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [31:0]              issue_v1,
    output logic [31:0]              issue_v2,
    output logic [TAG_W-1:0]         issue_rob,
    output logic [PAYLOAD_W-1:0]     issue_payload
);

    // Returns {hit, value}; buses are scanned high to low so the lowest matching bus wins.
    function automatic logic [32:0] cdb_match(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*TAG_W-1:0] tags,
        input logic [NUM_CDB*32-1:0]    vals
    );
        logic [32:0] res;
        res = '0;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (vld[b] && (tags[b*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, vals[b*32 +: 32]};
            end
        end
        return res;
    endfunction

    logic [DEPTH-1:0]     valid_vec;
    logic [DEPTH-1:0]     ready_vec;
    logic [DEPTH-1:0]     sel_vec;
    logic [DEPTH-1:0]     wr_vec;
    logic [DEPTH-1:0]     fire_vec;
    logic [DEPTH-1:0]     older_vec   [DEPTH];
    logic [31:0]          v1_arr      [DEPTH];
    logic [31:0]          v2_arr      [DEPTH];
    logic [TAG_W-1:0]     rob_arr     [DEPTH];
    logic [PAYLOAD_W-1:0] payload_arr [DEPTH];
    logic [32:0]          disp_snp1;
    logic [32:0]          disp_snp2;
    logic                 disp_fire;

    assign full      = &valid_vec;
    assign disp_fire = disp_valid && !full && !flush;
    assign disp_snp1 = cdb_match(disp_tag1, cdb_valid, cdb_tag, cdb_value);
    assign disp_snp2 = cdb_match(disp_tag2, cdb_valid, cdb_tag, cdb_value);

    // One-hot write enable for the lowest-index free entry.
    always_comb begin
        wr_vec = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                wr_vec    = '0;
                wr_vec[i] = disp_fire;
            end
        end
    end

    // older_vec[j][i] set means entry j was dispatched before entry i.
    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_vec[i] = ready_vec[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_vec[j] && older_vec[j][i]) begin
                    sel_vec[i] = 1'b0;
                end
            end
        end
    end

    assign issue_valid = |ready_vec;
    assign fire_vec    = sel_vec & {DEPTH{issue_ready}};

    always_comb begin
        issue_v1      = '0;
        issue_v2      = '0;
        issue_rob     = '0;
        issue_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_vec[i]) begin
                issue_v1      = v1_arr[i];
                issue_v2      = v2_arr[i];
                issue_rob     = rob_arr[i];
                issue_payload = payload_arr[i];
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic                 valid_q;
        logic                 busy1_q;
        logic                 busy2_q;
        logic [TAG_W-1:0]     tag1_q;
        logic [TAG_W-1:0]     tag2_q;
        logic [31:0]          v1_q;
        logic [31:0]          v2_q;
        logic [TAG_W-1:0]     rob_q;
        logic [PAYLOAD_W-1:0] payload_q;
        logic [DEPTH-1:0]     older_q;
        logic [DEPTH-1:0]     older_d;
        logic [32:0]          snp1;
        logic [32:0]          snp2;

        assign snp1 = cdb_match(tag1_q, cdb_valid, cdb_tag, cdb_value);
        assign snp2 = cdb_match(tag2_q, cdb_valid, cdb_tag, cdb_value);

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                valid_q <= 1'b0;
                busy1_q <= 1'b0;
                busy2_q <= 1'b0;
            end else if (wr_vec[gi]) begin
                valid_q   <= 1'b1;
                busy1_q   <= disp_busy1 && !disp_snp1[32];
                busy2_q   <= disp_busy2 && !disp_snp2[32];
                tag1_q    <= disp_tag1;
                tag2_q    <= disp_tag2;
                v1_q      <= (disp_busy1 && disp_snp1[32]) ? disp_snp1[31:0] : disp_v1;
                v2_q      <= (disp_busy2 && disp_snp2[32]) ? disp_snp2[31:0] : disp_v2;
                rob_q     <= disp_rob;
                payload_q <= disp_payload;
            end else begin
                if (fire_vec[gi]) begin
                    valid_q <= 1'b0;
                end
                if (busy1_q && snp1[32]) begin
                    busy1_q <= 1'b0;
                    v1_q    <= snp1[31:0];
                end
                if (busy2_q && snp2[32]) begin
                    busy2_q <= 1'b0;
                    v2_q    <= snp2[31:0];
                end
            end
        end

        // A newly written entry is older than nobody; every other row marks it as younger.
        assign older_d = wr_vec[gi] ? '0 : (older_q | wr_vec);

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                older_q <= '0;
            end else begin
                older_q <= older_d;
            end
        end

        assign valid_vec[gi]   = valid_q;
        assign ready_vec[gi]   = valid_q && !busy1_q && !busy2_q;
        assign older_vec[gi]   = older_q;
        assign v1_arr[gi]      = v1_q;
        assign v2_arr[gi]      = v2_q;
        assign rob_arr[gi]     = rob_q;
        assign payload_arr[gi] = payload_q;
    end

endmodule
